// File: rtl/morse_rx.sv
// morse_rx - Morse code receiver with an output FIFO.
//
// Samples an on/off-keyed Morse line, measures mark and space durations in
// units of PRESCALER clocks, decodes each letter to uppercase ASCII, and
// pushes the characters into a first-word-fall-through FIFO. A word gap is
// reported as a single 0x20 after the letter that precedes it.
//
// Ports:
//   clk        - single clock, rising edge
//   arst_n     - asynchronous active-low reset
//   morse_in   - asynchronous key line, 1 = mark (tone on)
//   read_en    - pop the FIFO head (ignored while empty)
//   ascii_out  - FIFO head, valid while empty = 0
//   empty      - FIFO holds no entries
//   full       - FIFO holds DEPTH entries
//   overflow   - sticky, set when a decoded character is dropped
module morse_rx #(
  parameter int PRESCALER = 50_000_000,
  parameter int DEPTH     = 8
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       morse_in,
  input  logic       read_en,
  output logic [7:0] ascii_out,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int CW = $clog2(7 * PRESCALER + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_HALF = CW'(PRESCALER / 2);
  localparam logic [CW-1:0] C_TWO  = CW'(2 * PRESCALER);
  localparam logic [CW-1:0] C_FIVE = CW'(5 * PRESCALER);
  localparam logic [CW-1:0] C_MAX  = CW'(7 * PRESCALER);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // ITU code table. The code carries a leading 1 marking its length,
  // followed by the elements oldest first (0 = dot, 1 = dash).
  function automatic logic [7:0] f_decode(input logic [5:0] code, input logic inv);
    logic [7:0] ch;
    if (inv) begin
      ch = 8'h3F;
    end else begin
      case (code)
        6'b000101: ch = 8'h41; // A .-
        6'b011000: ch = 8'h42; // B -...
        6'b011010: ch = 8'h43; // C -.-.
        6'b001100: ch = 8'h44; // D -..
        6'b000010: ch = 8'h45; // E .
        6'b010010: ch = 8'h46; // F ..-.
        6'b001110: ch = 8'h47; // G --.
        6'b010000: ch = 8'h48; // H ....
        6'b000100: ch = 8'h49; // I ..
        6'b010111: ch = 8'h4A; // J .---
        6'b001101: ch = 8'h4B; // K -.-
        6'b010100: ch = 8'h4C; // L .-..
        6'b000111: ch = 8'h4D; // M --
        6'b000110: ch = 8'h4E; // N -.
        6'b001111: ch = 8'h4F; // O ---
        6'b010110: ch = 8'h50; // P .--.
        6'b011101: ch = 8'h51; // Q --.-
        6'b001010: ch = 8'h52; // R .-.
        6'b001000: ch = 8'h53; // S ...
        6'b000011: ch = 8'h54; // T -
        6'b001001: ch = 8'h55; // U ..-
        6'b010001: ch = 8'h56; // V ...-
        6'b001011: ch = 8'h57; // W .--
        6'b011001: ch = 8'h58; // X -..-
        6'b011011: ch = 8'h59; // Y -.--
        6'b011100: ch = 8'h5A; // Z --..
        6'b111111: ch = 8'h30; // 0 -----
        6'b101111: ch = 8'h31; // 1 .----
        6'b100111: ch = 8'h32; // 2 ..---
        6'b100011: ch = 8'h33; // 3 ...--
        6'b100001: ch = 8'h34; // 4 ....-
        6'b100000: ch = 8'h35; // 5 .....
        6'b110000: ch = 8'h36; // 6 -....
        6'b111000: ch = 8'h37; // 7 --...
        6'b111100: ch = 8'h38; // 8 ---..
        6'b111110: ch = 8'h39; // 9 ----.
        default:   ch = 8'h3F; // ?
      endcase
    end
    return ch;
  endfunction

  logic          r_sync1;
  logic          r_sync2;
  logic          w_s;
  logic          r_level;
  logic [CW-1:0] r_run;
  state_t        r_state;
  logic [5:0]    r_code;
  logic [2:0]    r_cnt;
  logic          r_invalid;
  logic          r_push;
  logic [7:0]    r_push_data;

  logic [7:0]    r_mem [0:DEPTH-1];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_empty;
  logic          r_full;
  logic          r_overflow;
  logic [7:0]    r_ascii;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;
  logic [PW-1:0] w_cnt_nxt;
  logic          w_empty_nxt;
  logic          w_full_nxt;
  logic [7:0]    w_head_nxt;

  assign w_s = r_sync2;

  // Two-flop synchronizer for the asynchronous key line.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= morse_in;
      r_sync2 <= r_sync1;
    end
  end

  // Run-length counter of the current synchronized level. While a level
  // change is visible on w_s, r_run still holds the length of the run
  // that just ended.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_level <= 1'b0;
      r_run   <= '0;
    end else if (w_s != r_level) begin
      r_level <= w_s;
      r_run   <= C_ONE;
    end else if (r_run < C_MAX) begin
      r_run <= r_run + C_ONE;
    end else begin
      r_run <= r_run;
    end
  end

  // Receive FSM: element classification, letter assembly and gap detection.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= ST_IDLE;
      r_code      <= 6'b000001;
      r_cnt       <= 3'd0;
      r_invalid   <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            r_state <= ST_MARK;
          end
        end
        ST_MARK: begin
          if (!w_s) begin
            if (r_run >= C_HALF) begin
              // Only five elements fit; any further element poisons the letter.
              if (r_cnt < 3'd5) begin
                r_code <= {r_code[4:0], (r_run >= C_TWO)};
                r_cnt  <= r_cnt + 3'd1;
              end else begin
                r_invalid <= 1'b1;
              end
              r_state <= ST_SPACE;
            end else if (r_cnt != 3'd0) begin
              r_state <= ST_SPACE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_SPACE: begin
          if (w_s) begin
            r_state <= ST_MARK;
          end else if (r_run == C_TWO) begin
            r_push      <= 1'b1;
            r_push_data <= f_decode(r_code, r_invalid);
            r_code      <= 6'b000001;
            r_cnt       <= 3'd0;
            r_invalid   <= 1'b0;
            r_state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_s) begin
            r_state <= ST_MARK;
          end else if (r_run == C_FIVE) begin
            r_push      <= 1'b1;
            r_push_data <= 8'h20;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO next-state: a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    w_pop  = read_en & ~r_empty;
    w_push = r_push & (~r_full | w_pop);
    w_drop = r_push & r_full & ~w_pop;

    if (w_push) begin
      w_wr_nxt = r_wr_ptr + PW'(1);
    end else begin
      w_wr_nxt = r_wr_ptr;
    end

    if (w_pop) begin
      w_rd_nxt = r_rd_ptr + PW'(1);
    end else begin
      w_rd_nxt = r_rd_ptr;
    end

    w_cnt_nxt   = w_wr_nxt - w_rd_nxt;
    w_empty_nxt = (w_cnt_nxt == PW'(0));
    w_full_nxt  = (w_cnt_nxt == PW'(DEPTH));

    // The new head may be the slot being written this very cycle.
    if (w_push && (w_rd_nxt == r_wr_ptr)) begin
      w_head_nxt = r_push_data;
    end else if (!w_empty_nxt) begin
      w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
    end else begin
      w_head_nxt = r_ascii;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
    end
  end

  // FIFO pointers, registered flags and head register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_ascii    <= 8'h00;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_empty  <= w_empty_nxt;
      r_full   <= w_full_nxt;
      r_ascii  <= w_head_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign ascii_out = r_ascii;
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_morse_rx.sv
// tb_morse_rx - self-checking bench for morse_rx (PRESCALER=100, DEPTH=8).
// Keys Morse patterns into the receiver, records the characters it should
// decode in a scoreboard queue, and compares them as the FIFO is drained.
module tb_morse_rx;

  localparam int P = 100;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       morse_in;
  logic       read_en;
  logic [7:0] ascii_out;
  logic       empty;
  logic       full;
  logic       overflow;

  always #5 clk = ~clk;

  morse_rx #(.PRESCALER(P), .DEPTH(D)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .morse_in  (morse_in),
    .read_en   (read_en),
    .ascii_out (ascii_out),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  typedef struct {
    string      code;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl [20];
  logic [7:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         auto_rd = 1'b0;
  bit         force_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold the key line at v for n clocks; pops and checks the FIFO head
  // every cycle while reading is enabled.
  task automatic level(input logic v, input int n);
    morse_in = v;
    for (int i = 0; i < n; i++) begin
      read_en = 1'b0;
      if ((auto_rd || force_rd) && !empty) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra char: got 0x%0h, expected none", ascii_out);
        end else begin
          check("fifo head", {24'd0, ascii_out}, {24'd0, exp_q.pop_front()});
        end
        read_en = 1'b1;
      end
      @(negedge clk);
    end
    read_en = 1'b0;
  endtask

  task automatic send_code(input string code);
    for (int i = 0; i < code.len(); i++) begin
      level(1'b1, (code[i] == 8'h2D) ? 3 * P : P);
      if (i < code.len() - 1) level(1'b0, P);
    end
  endtask

  task automatic send_letter(input int idx);
    send_code(tbl[idx].code);
    exp_q.push_back(tbl[idx].exp);
    level(1'b0, 3 * P);
  endtask

  function automatic int find(input logic [7:0] c);
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].exp == c) return i;
    end
    return -1;
  endfunction

  task automatic send_text(input string s);
    int idx;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h20) begin
        exp_q.push_back(8'h20);
        level(1'b0, 4 * P);
      end else begin
        idx = find(s[i]);
        if (idx < 0) begin
          n_vec++;
          n_err++;
          $display("FAIL encoder: got no code, expected one for 0x%0h", s[i]);
        end else begin
          send_letter(idx);
        end
      end
    end
  endtask

  task automatic drain(input int bound);
    auto_rd = 1'b1;
    for (int i = 0; i < bound && exp_q.size() != 0; i++) level(1'b0, 1);
    check("drain remaining", exp_q.size(), 0);
    level(1'b0, 2);
    check("empty after drain", {31'd0, empty}, 1);
  endtask

  task automatic pop_one(input string name);
    check({name, " not empty"}, {31'd0, empty}, 0);
    check(name, {24'd0, ascii_out}, {24'd0, exp_q.pop_front()});
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{".-",     8'h41};
    tbl[1]  = '{"-...",   8'h42};
    tbl[2]  = '{"-.-.",   8'h43};
    tbl[3]  = '{"-..",    8'h44};
    tbl[4]  = '{".",      8'h45};
    tbl[5]  = '{"..-.",   8'h46};
    tbl[6]  = '{"--.",    8'h47};
    tbl[7]  = '{"....",   8'h48};
    tbl[8]  = '{"..",     8'h49};
    tbl[9]  = '{"---",    8'h4F};
    tbl[10] = '{".-.",    8'h52};
    tbl[11] = '{"...",    8'h53};
    tbl[12] = '{"-",      8'h54};
    tbl[13] = '{"--..",   8'h5A};
    tbl[14] = '{"-----",  8'h30};
    tbl[15] = '{".....",  8'h35};
    tbl[16] = '{"----.",  8'h39};
    tbl[17] = '{"-.--",   8'h59};
    tbl[18] = '{"......", 8'h3F};
    tbl[19] = '{"..--",   8'h3F};

    // Reset values
    arst_n = 1'b0; morse_in = 1'b0; read_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ascii_out", {24'd0, ascii_out}, 0);
    check("reset empty", {31'd0, empty}, 1);
    check("reset full", {31'd0, full}, 0);
    check("reset overflow", {31'd0, overflow}, 0);
    arst_n = 1'b1;
    @(negedge clk);

    // "E" followed by a long space: letter then one word space
    auto_rd = 1'b1;
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h20);
    level(1'b1, P);
    level(1'b0, 10 * P);
    check("E scoreboard", exp_q.size(), 0);
    check("E empty", {31'd0, empty}, 1);

    // "SOS" held in the FIFO, no space before 500 low clocks
    auto_rd = 1'b0;
    send_letter(find(8'h53));
    send_letter(find(8'h4F));
    send_code(tbl[find(8'h53)].code);
    exp_q.push_back(8'h53);
    level(1'b0, 4 * P);
    pop_one("SOS S1");
    pop_one("SOS O");
    pop_one("SOS S2");
    check("SOS no early space", {31'd0, empty}, 1);
    exp_q.push_back(8'h20);
    level(1'b0, 150);
    pop_one("SOS word space");
    check("SOS empty after", {31'd0, empty}, 1);

    // Decode table, then one word gap
    auto_rd = 1'b1;
    for (int i = 0; i < 20; i++) send_letter(i);
    exp_q.push_back(8'h20);
    level(1'b0, 4 * P);
    drain(1000);

    // 30-clock glitches inside an element gap and inside a letter gap
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h20);
    level(1'b1, P); level(1'b0, 40); level(1'b1, 30); level(1'b0, 60);
    level(1'b1, P); level(1'b0, P);
    level(1'b1, P); level(1'b0, P); level(1'b1, 30); level(1'b0, 6 * P);
    drain(1000);

    // Loopback-style text
    send_text("CARS ARE RED");
    exp_q.push_back(8'h20);
    level(1'b0, 7 * P);
    drain(1000);

    // Nine letters with no reads: ninth and the word space are dropped
    auto_rd = 1'b0;
    for (int k = 0; k < 9; k++) begin
      send_code(tbl[k].code);
      if (k < 8) exp_q.push_back(tbl[k].exp);
      level(1'b0, 3 * P);
      if (k == 7) begin
        check("fill full", {31'd0, full}, 1);
        check("fill no overflow", {31'd0, overflow}, 0);
      end
    end
    check("drop overflow", {31'd0, overflow}, 1);
    check("drop full", {31'd0, full}, 1);
    level(1'b0, 4 * P);
    for (int k = 0; k < 8; k++) pop_one("kept entry");
    check("after drops empty", {31'd0, empty}, 1);
    check("after drops full", {31'd0, full}, 0);
    check("overflow sticky", {31'd0, overflow}, 1);

    // Reset in the middle of a dash with three entries queued
    send_letter(4);
    send_letter(12);
    send_letter(8);
    check("queued head", {24'd0, ascii_out}, 32'h45);
    level(1'b1, 150);
    arst_n = 1'b0;
    #1;
    check("async rst empty", {31'd0, empty}, 1);
    check("async rst full", {31'd0, full}, 0);
    check("async rst ascii", {24'd0, ascii_out}, 0);
    check("async rst overflow", {31'd0, overflow}, 0);
    exp_q.delete();
    morse_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    level(1'b0, 50);
    auto_rd = 1'b1;
    send_letter(12);
    exp_q.push_back(8'h20);
    level(1'b0, 4 * P);
    drain(1000);

    // Ninth push accepted when read_en coincides with it
    auto_rd = 1'b0;
    for (int k = 0; k < 8; k++) send_letter(k);
    check("refill full", {31'd0, full}, 1);
    send_code(tbl[8].code);
    exp_q.push_back(tbl[8].exp);
    level(1'b0, 203);
    force_rd = 1'b1;
    level(1'b0, 1);
    force_rd = 1'b0;
    level(1'b0, 2);
    check("push+pop overflow", {31'd0, overflow}, 0);
    check("push+pop full", {31'd0, full}, 1);
    exp_q.push_back(8'h20);
    drain(1000);
    check("final overflow", {31'd0, overflow}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
